// File: rtl/share_collector.sv
// rtl/share_collector.sv - leading-zero hit detector with hit FIFO and first-word-fall-through output
module share_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [5:0]                    target_zeros,
  input  logic                          in_valid,
  input  logic [63:0]                   in_nonce,
  input  logic [63:0]                   in_hash,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [63:0]                   out_nonce,
  output logic [63:0]                   out_hash,
  output logic [CNT_W-1:0]              hash_count,
  output logic [CNT_W-1:0]              hit_count,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {EMPTY, PRESENT} out_state_t;

  out_state_t    state;
  logic          s1_hit;
  logic [63:0]   s1_nonce;
  logic [63:0]   s1_hash;
  logic [63:0]   mem_nonce [FIFO_DEPTH];
  logic [63:0]   mem_hash  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_nxt;
  logic [63:0]   zero_mask;
  logic          qual;
  logic          hit_now;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Mask covers the top target_zeros bits; N=0 yields an empty mask so everything hits.
  assign zero_mask = ~({64{1'b1}} >> target_zeros);
  assign hit_now   = ((in_hash & zero_mask) == 64'd0);
  assign qual      = in_valid && enable;
  assign full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = s1_hit && (!full || pop);
  assign drop      = s1_hit && full && !pop;

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + (AW+1)'(1);
    else if (pop && !push)
      level_nxt = fifo_level - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit     <= 1'b0;
      s1_nonce   <= '0;
      s1_hash    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hash_count <= '0;
      hit_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      state      <= EMPTY;
      out_valid  <= 1'b0;
    end else begin
      s1_hit   <= qual && hit_now;
      s1_nonce <= in_nonce;
      s1_hash  <= in_hash;
      if (qual && hash_count != {CNT_W{1'b1}})
        hash_count <= hash_count + CNT_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (hit_count != {CNT_W{1'b1}})
          hit_count <= hit_count + CNT_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end
      fifo_level <= level_nxt;
      case (state)
        EMPTY: if (level_nxt != '0) begin
          state     <= PRESENT;
          out_valid <= 1'b1;
        end
        PRESENT: if (level_nxt == '0) begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset: occupancy is tracked by the pointers and the output is gated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce[wr_ptr] <= s1_nonce;
      mem_hash[wr_ptr]  <= s1_hash;
    end
  end

  assign out_nonce = out_valid ? mem_nonce[rd_ptr] : 64'd0;
  assign out_hash  = out_valid ? mem_hash[rd_ptr]  : 64'd0;

endmodule

// File: tb/tb_share_collector.sv
// tb/tb_share_collector.sv - directed stimulus against a queue-based reference of share_collector
module tb_share_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [5:0]  target_zeros;
  logic        in_valid;
  logic [63:0] in_nonce;
  logic [63:0] in_hash;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_nonce;
  logic [63:0] out_hash;
  logic [31:0] hash_count;
  logic [31:0] hit_count;
  logic [15:0] drop_count;
  logic [2:0]  fifo_level;
  logic        overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  share_collector #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .target_zeros(target_zeros),
    .in_valid(in_valid), .in_nonce(in_nonce), .in_hash(in_hash),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce), .out_hash(out_hash),
    .hash_count(hash_count), .hit_count(hit_count), .drop_count(drop_count),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] n;
    logic [63:0] h;
  } ent_t;

  ent_t        m_q[$];
  bit          m_s1_hit;
  ent_t        m_s1;
  longint      m_hash_cnt, m_hit_cnt, m_drop_cnt;
  bit          m_ovf;

  function automatic bit m_is_hit(logic [63:0] h, int n);
    for (int i = 0; i < n; i++)
      if (h[63-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the hit queue is the FIFO content, the head is what must be presented.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_s1_hit   = 1'b0;
      m_hash_cnt = 0;
      m_hit_cnt  = 0;
      m_drop_cnt = 0;
      m_ovf      = 1'b0;
    end else begin
      bit pop_now;
      pop_now = (m_q.size() > 0) && out_ready;
      if (pop_now) void'(m_q.pop_front());
      if (m_s1_hit) begin
        if (m_q.size() >= DEPTH) begin
          m_drop_cnt++;
          m_ovf = 1'b1;
        end else begin
          m_q.push_back(m_s1);
          m_hit_cnt++;
        end
      end
      m_s1_hit = 1'b0;
      if (in_valid && enable) begin
        m_hash_cnt++;
        m_s1_hit = m_is_hit(in_hash, int'(target_zeros));
        m_s1.n = in_nonce;
        m_s1.h = in_hash;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("m_valid", out_valid, (m_q.size() > 0));
      check("m_nonce", out_nonce, (m_q.size() > 0) ? m_q[0].n : 64'd0);
      check("m_hash", out_hash, (m_q.size() > 0) ? m_q[0].h : 64'd0);
      check("m_hash_count", hash_count, m_hash_cnt);
      check("m_hit_count", hit_count, m_hit_cnt);
      check("m_drop_count", drop_count, m_drop_cnt);
      check("m_level", fifo_level, m_q.size());
      check("m_overflow", overflow, m_ovf);
    end
  end

  task automatic cyc(input logic v, input logic [63:0] n, input logic [63:0] h);
    in_valid = v;
    in_nonce = n;
    in_hash  = h;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; target_zeros = 6'd8; in_valid = 1'b0;
    in_nonce = '0; in_hash = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_hash_count", hash_count, 0);
    rst = 1'b0;

    // Single hit with N=8 appears after the second edge.
    cyc(1, 64'd5, 64'h00FF_0000_0000_0000);
    check("hit_lat1_valid", out_valid, 0);
    check("hit_hash_count", hash_count, 1);
    cyc(0, 0, 0);
    check("hit_lat2_valid", out_valid, 1);
    check("hit_nonce", out_nonce, 5);
    check("hit_hit_count", hit_count, 1);
    cyc(0, 0, 0);
    check("hit_popped", out_valid, 0);

    // Miss: bit 56 set with N=8.
    cyc(1, 64'd7, 64'h0100_0000_0000_0000);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("miss_valid", out_valid, 0);
    check("miss_hash_count", hash_count, 2);
    check("miss_hit_count", hit_count, 1);

    // N=0 overfill with no consumer.
    target_zeros = 6'd0; out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) cyc(1, i, 64'hFFFF_0000_0000_0000 | i);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("ovf_level", fifo_level, 4);
    check("ovf_drops", drop_count, 2);
    check("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", out_nonce, i);
      cyc(0, 0, 0);
    end
    check("ovf_drained", out_valid, 0);

    // Full FIFO with simultaneous write and pop every cycle.
    out_ready = 1'b0;
    for (int i = 10; i <= 14; i++) cyc(1, i, 64'd0);
    check("full_level", fifo_level, 4);
    out_ready = 1'b1;
    for (int i = 15; i <= 24; i++) begin
      check("full_head", out_nonce, i - 5);
      cyc(1, i, 64'd0);
      check("full_level_hold", fifo_level, 4);
    end
    check("full_no_drop", drop_count, 2);
    repeat (6) cyc(0, 0, 0);
    check("full_hit_count", hit_count, 20);
    check("full_hash_count", hash_count, 23);

    // N=63 boundary: only bit 0 may be set.
    target_zeros = 6'd63;
    cyc(1, 64'd50, 64'd1);
    cyc(1, 64'd51, 64'd2);
    check("n63_hit_nonce", out_nonce, 50);
    cyc(0, 0, 0);
    check("n63_miss", out_valid, 0);

    // Reset while three hits are buffered.
    target_zeros = 6'd0; out_ready = 1'b0;
    cyc(1, 64'd30, 64'd0);
    cyc(1, 64'd31, 64'd0);
    cyc(1, 64'd32, 64'd0);
    cyc(0, 0, 0);
    check("pre_rst_level", fifo_level, 3);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_hash_count", hash_count, 0);
    check("rst_mid_hit_count", hit_count, 0);
    check("rst_mid_drop", drop_count, 0);
    check("rst_mid_nonce", out_nonce, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc(0, 0, 0);
    check("post_rst_valid", out_valid, 0);

    // Disable stops counting but buffered hits still drain.
    out_ready = 1'b0;
    cyc(1, 64'd40, 64'd0);
    cyc(0, 0, 0);
    enable = 1'b0;
    cyc(1, 64'd41, 64'd0);
    cyc(1, 64'd42, 64'd0);
    check("dis_hash_count", hash_count, 1);
    check("dis_nonce", out_nonce, 40);
    out_ready = 1'b1;
    cyc(0, 0, 0);
    check("dis_popped", out_valid, 0);
    check("dis_level", fifo_level, 0);

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
